instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// ============================================================================
//  Module   : instr_sequencer
//  Brief    : Presents stored instructions to a datapath, each held for a fixed
//             number of cycles, with looping, abort and zero-flag counting.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int INSTR_W     = 32,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 5,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [AW:0]        num_instr,
  input  logic               loop_en,
  input  logic               abort,
  input  logic               zf,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      idx,
  output logic [AW:0]        zf_count
);

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [AW:0]          count_q, count_d;
  logic [AW:0]          zf_count_q, zf_count_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic                 last_hold;
  logic                 last_entry;

  assign last_hold  = (hold_q == HOLD_LAST);
  assign last_entry = ({1'b0, idx_q} == (count_q - (AW + 1)'(1)));

  // Store is written only while idle and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && load_en && (state_q == S_IDLE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      zf_count_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      zf_count_q <= zf_count_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    zf_count_d = zf_count_q;
    hold_d     = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_instr == '0) begin
            state_d = S_FIN;
          end else begin
            count_d    = (num_instr > DEPTH_CNT) ? DEPTH_CNT : num_instr;
            zf_count_d = '0;
            idx_d      = '0;
            hold_d     = '0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Abort takes precedence, including over the final hold completion.
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_hold) begin
          hold_d = '0;
          if (zf && !(&zf_count_q)) begin
            zf_count_d = zf_count_q + (AW + 1)'(1);
          end
          if (!last_entry) begin
            idx_d = idx_q + AW'(1);
          end else if (loop_en) begin
            idx_d = '0;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    instr       = '0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_RUN: begin
        instr       = mem_q[idx_q];
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign idx      = idx_q;
  assign zf_count = zf_count_q;

endmodule

`default_nettype wire
